// File: rtl/spi_tx_scheduler.sv
// Round-robin scheduler sharing one SPI mode-0 transmit link between lanes.
// Ports: clk_in/reset_in; req_in/data_in per lane; grant/busy/done status; cs_n/sclk/mosi serial.
module spi_tx_scheduler #(
  parameter int SIZE       = 8,
  parameter int REQUESTERS = 2,
  parameter int CLK_DIV    = 2
) (
  input  logic                         clk_in,
  input  logic                         reset_in,
  input  logic [REQUESTERS-1:0]        req_in,
  input  logic [REQUESTERS*SIZE-1:0]   data_in,
  output logic [REQUESTERS-1:0]        grant_out,
  output logic                         busy_out,
  output logic                         done_out,
  output logic                         cs_n_out,
  output logic                         sclk_out,
  output logic                         mosi_out
);

  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam int BW = $clog2(SIZE) + 1;
  localparam int PW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  typedef enum logic [1:0] {
    IDLE, SETUP, SHIFT, DONE
  } state_t;

  state_t                state_q;
  logic [PW-1:0]         rr_q;
  logic [PW-1:0]         lane_q;
  logic [DW-1:0]         div_q;
  logic [BW-1:0]         bit_q;
  logic [SIZE-1:0]       sreg_q;
  logic [REQUESTERS-1:0] grant_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  cs_n_q;
  logic                  sclk_q;
  logic                  mosi_q;

  logic                  pick_vld;
  logic [PW-1:0]         pick_idx;
  logic [SIZE-1:0]       pick_word;
  logic                  div_end;

  // First requesting lane at or above rr_q, wrapping around.
  always_comb begin
    int j;
    j        = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      j = (int'(rr_q) + i) % REQUESTERS;
      if (!pick_vld && req_in[j]) begin
        pick_vld = 1'b1;
        pick_idx = PW'(j);
      end
    end
  end

  assign pick_word = data_in[int'(pick_idx)*SIZE +: SIZE];
  assign div_end   = (div_q == DW'(CLK_DIV - 1));

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      rr_q    <= '0;
      lane_q  <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      sreg_q  <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      grant_q <= '0;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pick_vld) begin
            state_q <= SETUP;
            lane_q  <= pick_idx;
            sreg_q  <= pick_word;
            grant_q <= REQUESTERS'(1) << pick_idx;
            busy_q  <= 1'b1;
            cs_n_q  <= 1'b0;
            mosi_q  <= pick_word[SIZE-1];
            div_q   <= '0;
            bit_q   <= BW'(SIZE - 1);
          end
        end
        SETUP: begin
          if (div_end) begin
            div_q   <= '0;
            sclk_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        SHIFT: begin
          if (!div_end) begin
            div_q <= div_q + DW'(1);
          end else begin
            div_q <= '0;
            if (sclk_q) begin
              // Falling edge: present next bit, last bit is held.
              sclk_q <= 1'b0;
              if (bit_q != '0) begin
                sreg_q <= {sreg_q[SIZE-2:0], sreg_q[SIZE-1]};
                mosi_q <= sreg_q[SIZE-2];
              end
            end else if (bit_q == '0) begin
              state_q <= DONE;
              cs_n_q  <= 1'b1;
              mosi_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              bit_q  <= bit_q - BW'(1);
              sclk_q <= 1'b1;
            end
          end
        end
        DONE: begin
          rr_q    <= (lane_q == PW'(REQUESTERS - 1)) ? '0 : lane_q + PW'(1);
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_out = grant_q;
  assign busy_out  = busy_q;
  assign done_out  = done_q;
  assign cs_n_out  = cs_n_q;
  assign sclk_out  = sclk_q;
  assign mosi_out  = mosi_q;

endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Directed bench for spi_tx_scheduler: default build (8/2/2) plus a
// SIZE=2, CLK_DIV=1, single-lane build.
module tb_spi_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_a;
  logic [15:0] data_a;
  logic [1:0]  grant_a;
  logic        busy_a, done_a, cs_a, sclk_a, mosi_a;
  logic [0:0]  req_b;
  logic [1:0]  data_b;
  logic [0:0]  grant_b;
  logic        busy_b, done_b, cs_b, sclk_b, mosi_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_tx_scheduler #(.SIZE(8), .REQUESTERS(2), .CLK_DIV(2)) dut_a (
    .clk_in(clk), .reset_in(rst), .req_in(req_a), .data_in(data_a),
    .grant_out(grant_a), .busy_out(busy_a), .done_out(done_a),
    .cs_n_out(cs_a), .sclk_out(sclk_a), .mosi_out(mosi_a)
  );

  spi_tx_scheduler #(.SIZE(2), .REQUESTERS(1), .CLK_DIV(1)) dut_b (
    .clk_in(clk), .reset_in(rst), .req_in(req_b), .data_in(data_b),
    .grant_out(grant_b), .busy_out(busy_b), .done_out(done_b),
    .cs_n_out(cs_b), .sclk_out(sclk_b), .mosi_out(mosi_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Starts on the grant cycle; returns on the first cycle cs_n is high.
  task automatic frame_a(output logic [7:0] w, output int low,
                         output int rises, output bit to);
    logic p;
    w = '0; low = 1; rises = 0; p = sclk_a; to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (cs_a) begin
        to = 1'b0;
        break;
      end
      low++;
      if (sclk_a && !p) begin
        rises++;
        w = {w[6:0], mosi_a};
      end
      p = sclk_a;
    end
  endtask

  task automatic wait_grant(output int hi, output bit to);
    hi = 0; to = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (grant_a != 2'b00) begin
        to = 1'b0;
        break;
      end
      if (cs_a) hi++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_a = '0; data_a = '0; req_b = '0; data_b = '0;
    repeat (10) step();
    checks++;
    if ({cs_a, sclk_a, mosi_a, grant_a, busy_a, done_a} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 1000000",
               {cs_a, sclk_a, mosi_a, grant_a, busy_a, done_a});
    end
    checks++;
    if ({cs_b, sclk_b, mosi_b, grant_b, busy_b, done_b} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_outputs_b: got %b want 100000",
               {cs_b, sclk_b, mosi_b, grant_b, busy_b, done_b});
    end
    rst = 1'b0;
    step();
    checks++;
    if (cs_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: cs=%b busy=%b want 1 0", cs_a, busy_a);
    end
  endtask

  task automatic test_single();
    logic [7:0] w; int low, rises; bit to;
    data_a = {8'h00, 8'b10101100};
    req_a  = 2'b01;
    step();
    checks++;
    if (grant_a !== 2'b01 || cs_a !== 1'b0 || busy_a !== 1'b1 || mosi_a !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: grant=%b cs=%b busy=%b mosi=%b want 01 0 1 1",
               grant_a, cs_a, busy_a, mosi_a);
    end
    req_a = 2'b00;
    step();
    checks++;
    if (grant_a !== 2'b00) begin
      errors++;
      $display("FAIL single_grant_pulse: grant=%b want 00", grant_a);
    end
    frame_a(w, low, rises, to);
    low++;
    checks++;
    if (to || low != 34) begin
      errors++;
      $display("FAIL single_cs_low: got %0d cycles (timeout %0d) want 34", low, to);
    end
    checks++;
    if (rises != 8 || w !== 8'b10101100) begin
      errors++;
      $display("FAIL single_word: rises=%0d word=%b want 8 10101100", rises, w);
    end
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL single_done: done=%b busy=%b want 1 1", done_a, busy_a);
    end
    step();
    checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b0 || cs_a !== 1'b1) begin
      errors++;
      $display("FAIL single_after_done: done=%b busy=%b cs=%b want 0 0 1",
               done_a, busy_a, cs_a);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] w; int low, rises, hi; bit to;
    logic [1:0] eg;
    logic [7:0] ew;
    do_reset();
    data_a = {8'h3C, 8'hA5};
    req_a  = 2'b11;
    for (int f = 0; f < 4; f++) begin
      eg = (f % 2 == 0) ? 2'b01 : 2'b10;
      ew = (f % 2 == 0) ? 8'hA5 : 8'h3C;
      wait_grant(hi, to);
      checks++;
      if (to || grant_a !== eg) begin
        errors++;
        $display("FAIL rr_grant%0d: got %b want %b", f, grant_a, eg);
      end
      if (f > 0) begin
        checks++;
        if (hi + 1 != 2) begin
          errors++;
          $display("FAIL rr_gap%0d: cs high %0d cycles want 2", f, hi + 1);
        end
      end
      frame_a(w, low, rises, to);
      checks++;
      if (to || w !== ew) begin
        errors++;
        $display("FAIL rr_word%0d: got %h want %h", f, w, ew);
      end
    end
    req_a = 2'b00;
    step();
  endtask

  task automatic test_data_change();
    logic [7:0] w; int low, rises; bit to;
    do_reset();
    data_a = {8'h00, 8'hAC};
    req_a  = 2'b01;
    step();
    req_a  = 2'b00;
    data_a = {8'h00, 8'hFF};
    frame_a(w, low, rises, to);
    checks++;
    if (to || w !== 8'hAC) begin
      errors++;
      $display("FAIL data_change_word: got %h want ac", w);
    end
    step();
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] w; int low, rises, hi, dn; bit to;
    logic p;
    do_reset();
    data_a = {8'h3C, 8'hAC};
    req_a  = 2'b01;
    step();
    req_a = 2'b00;
    frame_a(w, low, rises, to);
    step();
    req_a = 2'b01;
    wait_grant(hi, to);
    req_a = 2'b00;
    rises = 0; p = sclk_a;
    for (int i = 0; i < 100 && rises < 4; i++) begin
      step();
      if (sclk_a && !p) rises++;
      p = sclk_a;
    end
    rst = 1'b1;
    step();
    checks++;
    if (cs_a !== 1'b1 || sclk_a !== 1'b0 || done_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: cs=%b sclk=%b done=%b busy=%b want 1 0 0 0",
               cs_a, sclk_a, done_a, busy_a);
    end
    rst = 1'b0;
    req_a = 2'b11;
    dn = 0;
    to = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done_a) dn++;
      if (grant_a != 2'b00) begin
        to = 1'b0;
        break;
      end
    end
    checks++;
    if (to || grant_a !== 2'b01 || dn != 0) begin
      errors++;
      $display("FAIL abort_regrant: grant=%b dones=%0d want 01 0", grant_a, dn);
    end
    req_a = 2'b00;
    frame_a(w, low, rises, to);
    step();
  endtask

  task automatic test_small();
    logic [7:0] pat; logic [1:0] bits; int low, rises; logic p; bit to;
    do_reset();
    data_b = 2'b10;
    req_b  = 1'b1;
    step();
    checks++;
    if (grant_b !== 1'b1 || cs_b !== 1'b0) begin
      errors++;
      $display("FAIL small_grant: grant=%b cs=%b want 1 0", grant_b, cs_b);
    end
    pat = {7'b0, sclk_b}; low = 1; rises = 0; bits = '0; p = sclk_b; to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (cs_b) begin
        to = 1'b0;
        break;
      end
      low++;
      pat = {pat[6:0], sclk_b};
      if (sclk_b && !p) begin
        rises++;
        bits = {bits[0], mosi_b};
      end
      p = sclk_b;
    end
    checks++;
    if (to || low != 5 || pat !== 8'b00001010) begin
      errors++;
      $display("FAIL small_frame: low=%0d sclk=%b want 5 00001010", low, pat);
    end
    checks++;
    if (rises != 2 || bits !== 2'b10 || done_b !== 1'b1) begin
      errors++;
      $display("FAIL small_bits: rises=%0d bits=%b done=%b want 2 10 1",
               rises, bits, done_b);
    end
    step();
    step();
    checks++;
    if (grant_b !== 1'b1) begin
      errors++;
      $display("FAIL small_regrant: grant=%b want 1", grant_b);
    end
    req_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_data_change();
    test_reset_mid_frame();
    test_small();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
